otter_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the cached Memory block and drives its port 1. It holds the PC and issues word reads over the MEM_RDEN1/MEM_ADDR1/memValid1 handshake, tolerating variable miss latency. Returned words go into a small FIFO that feeds decode through a valid/ready interface. The block supports pipeline flush/redirect without aborting a read that is already in flight.

---
 rtl/otter_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_otter_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads on memory port 1 and
// buffers returned instructions in a small FIFO feeding decode.
module otter_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ADDR_W     = 14
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FLUSH,
  input  logic [31:0]       FLUSH_PC,
  output logic              MEM_RDEN1,
  output logic [ADDR_W-1:0] MEM_ADDR1,
  input  logic [31:0]       MEM_DOUT1,
  input  logic              memValid1,
  output logic              IR_VALID,
  input  logic              IR_READY,
  output logic [31:0]       IR,
  output logic [31:0]       IR_PC
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [31:0]       pc, pc_nxt;
  logic [31:0]       flush_tgt;
  logic [ADDR_W-1:0] addr_nxt;

  logic [31:0]      ir_q [FIFO_DEPTH];
  logic [31:0]      pc_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, occ_pop;
  logic             push, pop, clr, room_idle, room_req;

  assign IR_VALID  = (count != '0);
  assign IR        = ir_q[rd_ptr];
  assign IR_PC     = pc_q[rd_ptr];
  assign flush_tgt = FLUSH_PC & ~32'h3;

  // Room is judged on occupancy after this cycle's pop, so a full FIFO being
  // drained still keeps requests back-to-back.
  assign occ_pop   = count - CNT_W'(pop);
  assign room_idle = occ_pop < DEPTH_C;
  assign room_req  = (occ_pop + CNT_W'(1)) < DEPTH_C;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    addr_nxt  = MEM_ADDR1;
    push      = 1'b0;
    clr       = 1'b0;
    pop       = IR_VALID && IR_READY && !FLUSH;
    if (FLUSH) begin
      clr    = 1'b1;
      pc_nxt = flush_tgt;
      // An in-flight read cannot be aborted: address stays put until it returns.
      case (state)
        IDLE: begin
          state_nxt = REQ;
          addr_nxt  = flush_tgt[ADDR_W+1:2];
        end
        REQ: begin
          if (memValid1) addr_nxt = flush_tgt[ADDR_W+1:2];
          else           state_nxt = DRAIN;
        end
        DRAIN: begin
          if (memValid1) begin
            state_nxt = REQ;
            addr_nxt  = flush_tgt[ADDR_W+1:2];
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (room_idle) begin
            state_nxt = REQ;
            addr_nxt  = pc[ADDR_W+1:2];
          end
        end
        REQ: begin
          if (memValid1) begin
            push   = 1'b1;
            pc_nxt = pc + 32'd4;
            if (room_req) addr_nxt  = pc_nxt[ADDR_W+1:2];
            else          state_nxt = IDLE;
          end
        end
        DRAIN: begin
          if (memValid1) begin
            state_nxt = REQ;
            addr_nxt  = pc[ADDR_W+1:2];
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      MEM_RDEN1 <= 1'b0;
      MEM_ADDR1 <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      MEM_RDEN1 <= (state_nxt != IDLE);
      MEM_ADDR1 <= addr_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        ir_q[i] <= '0;
        pc_q[i] <= '0;
      end
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ir_q[wr_ptr] <= MEM_DOUT1;
        pc_q[wr_ptr] <= pc;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assert property (@(posedge CLK) disable iff (!RST_N)
    !(push && (count == DEPTH_C) && !pop));

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Bench for otter_fetch_unit: behavioural memory with programmable latency and
// a scoreboard of expected {IR, IR_PC} checked at every decode handshake.
module tb_otter_fetch_unit;

  localparam int unsigned AW = 14;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          FLUSH;
  logic [31:0]   FLUSH_PC;
  logic          MEM_RDEN1;
  logic [AW-1:0] MEM_ADDR1;
  logic [31:0]   MEM_DOUT1;
  logic          memValid1;
  logic          IR_VALID;
  logic          IR_READY;
  logic [31:0]   IR;
  logic [31:0]   IR_PC;

  otter_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .FLUSH_PC(FLUSH_PC),
    .MEM_RDEN1(MEM_RDEN1), .MEM_ADDR1(MEM_ADDR1), .MEM_DOUT1(MEM_DOUT1),
    .memValid1(memValid1), .IR_VALID(IR_VALID), .IR_READY(IR_READY),
    .IR(IR), .IR_PC(IR_PC)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    int unsigned lat;
    int unsigned nwords;
    int unsigned exp_gaps;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  logic          mem_auto = 1'b1;
  int unsigned   lat = 3;
  logic          busy = 1'b0;
  logic [AW-1:0] cur = '0;
  int unsigned   cnt = 0;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {2'b10, a, 2'b01, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [31:0] pc);
    exp_t e;
    e.ir = mem_word(a);
    e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rden"}, 32'(MEM_RDEN1), 32'd0);
    chk({tag, "_addr"}, 32'(MEM_ADDR1), 32'd0);
    chk({tag, "_irvalid"}, 32'(IR_VALID), 32'd0);
    chk({tag, "_ir"}, IR, 32'd0);
    chk({tag, "_irpc"}, IR_PC, 32'd0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    FLUSH = 1'b0;
    FLUSH_PC = '0;
    IR_READY = 1'b0;
    mem_auto = 1'b1;
    #1;
    check_reset_vals("reset");
    step();
    step();
    sb.delete();
    RST_N = 1'b1;
  endtask

  task automatic drain_sb(input string name, input int unsigned budget);
    for (int unsigned i = 0; i < budget && sb.size() != 0; i++) step();
    IR_READY = 1'b0;
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  // Memory model: picks up a request, checks it is held, answers after lat cycles.
  initial begin
    memValid1 = 1'b0;
    MEM_DOUT1 = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (!RST_N) begin
        busy = 1'b0;
        memValid1 = 1'b0;
      end else begin
        if (memValid1) begin
          memValid1 = 1'b0;
          busy = 1'b0;
        end
        if (mem_auto) begin
          if (busy) begin
            chk("addr_hold", 32'(MEM_ADDR1), 32'(cur));
            chk("rden_hold", 32'(MEM_RDEN1), 32'd1);
          end else if (MEM_RDEN1) begin
            busy = 1'b1;
            cur = MEM_ADDR1;
            cnt = lat;
          end
          if (busy) begin
            if (cnt <= 1) begin
              memValid1 = 1'b1;
              MEM_DOUT1 = mem_word(cur);
            end else cnt--;
          end
        end
      end
    end
  end

  // Decode side: each accepted instruction is popped from the scoreboard.
  always @(negedge CLK) begin
    if (RST_N && IR_VALID && IR_READY && !FLUSH) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pop: got IR %h IR_PC %h expected none", IR, IR_PC);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ir", IR, e.ir);
        chk("ir_pc", IR_PC, e.pc);
      end
    end
  end

  initial begin
    vec_t vecs[3];
    int unsigned gaps;
    logic seen;
    RST_N = 1'b0;
    FLUSH = 1'b0;
    FLUSH_PC = '0;
    IR_READY = 1'b0;
    vecs[0] = '{lat: 3, nwords: 6, exp_gaps: 0};
    vecs[1] = '{lat: 1, nwords: 6, exp_gaps: 0};
    vecs[2] = '{lat: 2, nwords: 5, exp_gaps: 0};
    #3;

    // Streaming fetch at several latencies with decode always ready.
    for (int v = 0; v < 3; v++) begin
      lat = vecs[v].lat;
      do_reset();
      for (int unsigned k = 0; k < vecs[v].nwords; k++) push_exp(AW'(k), 32'(k * 4));
      IR_READY = 1'b1;
      gaps = 0;
      seen = 1'b0;
      for (int unsigned i = 0; i < 300 && sb.size() != 0; i++) begin
        step();
        if (MEM_RDEN1) seen = 1'b1;
        else if (seen && sb.size() != 0) gaps++;
      end
      IR_READY = 1'b0;
      chk("stream_done", 32'(sb.size()), 32'd0);
      chk("stream_gaps", gaps, vecs[v].exp_gaps);
    end

    // Back-pressure: two words buffered, then fetch resumes at PC 0x8.
    lat = 1;
    do_reset();
    for (int unsigned k = 0; k < 4; k++) push_exp(AW'(k), 32'(k * 4));
    repeat (10) step();
    chk("bp_irvalid", 32'(IR_VALID), 32'd1);
    chk("bp_rden_low", 32'(MEM_RDEN1), 32'd0);
    IR_READY = 1'b1;
    step();
    chk("bp_resume_rden", 32'(MEM_RDEN1), 32'd1);
    chk("bp_resume_addr", 32'(MEM_ADDR1), 32'd2);
    drain_sb("bp_done", 100);

    // Flush while the read at word 5 is outstanding.
    lat = 6;
    do_reset();
    for (int unsigned k = 0; k < 5; k++) push_exp(AW'(k), 32'(k * 4));
    IR_READY = 1'b1;
    for (int unsigned i = 0; i < 100 && !(MEM_RDEN1 && MEM_ADDR1 == AW'(5)); i++) step();
    chk("fl1_at5", 32'(MEM_ADDR1), 32'd5);
    step();
    chk("fl1_pre_empty", 32'(sb.size()), 32'd0);
    FLUSH = 1'b1;
    FLUSH_PC = 32'h100;
    step();
    FLUSH = 1'b0;
    chk("fl1_rden", 32'(MEM_RDEN1), 32'd1);
    chk("fl1_addr_held", 32'(MEM_ADDR1), 32'd5);
    push_exp(AW'(32'h40), 32'h100);
    push_exp(AW'(32'h41), 32'h104);
    for (int unsigned i = 0; i < 50 && MEM_ADDR1 == AW'(5); i++) step();
    chk("fl1_new_addr", 32'(MEM_ADDR1), 32'h40);
    drain_sb("fl1_done", 100);

    // Flush coincident with memValid1 and a pending pop.
    lat = 3;
    do_reset();
    for (int unsigned i = 0; i < 100 && !(memValid1 && IR_VALID); i++) step();
    chk("fl2_setup", 32'(memValid1 && IR_VALID), 32'd1);
    FLUSH = 1'b1;
    FLUSH_PC = 32'h203;
    IR_READY = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("fl2_irvalid", 32'(IR_VALID), 32'd0);
    chk("fl2_rden", 32'(MEM_RDEN1), 32'd1);
    chk("fl2_addr", 32'(MEM_ADDR1), 32'h80);
    push_exp(AW'(32'h80), 32'h200);
    push_exp(AW'(32'h81), 32'h204);
    drain_sb("fl2_done", 100);

    // Two flushes during one drain: only the second target is fetched.
    lat = 8;
    do_reset();
    IR_READY = 1'b1;
    for (int unsigned i = 0; i < 20 && !MEM_RDEN1; i++) step();
    FLUSH = 1'b1;
    FLUSH_PC = 32'h40;
    step();
    FLUSH_PC = 32'h80;
    step();
    FLUSH = 1'b0;
    chk("fl3_rden", 32'(MEM_RDEN1), 32'd1);
    chk("fl3_addr_held", 32'(MEM_ADDR1), 32'd0);
    push_exp(AW'(32'h20), 32'h80);
    push_exp(AW'(32'h21), 32'h84);
    for (int unsigned i = 0; i < 50 && MEM_ADDR1 == '0; i++) step();
    chk("fl3_new_addr", 32'(MEM_ADDR1), 32'h20);
    drain_sb("fl3_done", 100);

    // Reset mid-miss followed by a stale memValid1 in IDLE.
    lat = 5;
    do_reset();
    push_exp(AW'(0), 32'h0);
    push_exp(AW'(1), 32'h4);
    IR_READY = 1'b1;
    for (int unsigned i = 0; i < 100 && MEM_ADDR1 != AW'(2); i++) step();
    step();
    chk("rst_pre_empty", 32'(sb.size()), 32'd0);
    mem_auto = 1'b0;
    RST_N = 1'b0;
    #1;
    check_reset_vals("midreset");
    step();
    step();
    RST_N = 1'b1;
    memValid1 = 1'b1;
    MEM_DOUT1 = 32'hDEAD_BEEF;
    step();
    memValid1 = 1'b0;
    chk("stale_irvalid", 32'(IR_VALID), 32'd0);
    chk("stale_rden", 32'(MEM_RDEN1), 32'd1);
    chk("stale_addr", 32'(MEM_ADDR1), 32'd0);
    mem_auto = 1'b1;
    for (int unsigned k = 0; k < 3; k++) push_exp(AW'(k), 32'(k * 4));
    drain_sb("rst_done", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
